// File: rtl/reg_file_sb_if.sv
// Decode/dispatch/write-back bundle for the scoreboarded register file.
// The master side is the pipeline, the slave side is reg_file_sb.
interface reg_file_sb_if #(
  parameter int unsigned LEN_WORD     = 32,
  parameter int unsigned LEN_REG_ADDR = 6
);
  logic [LEN_REG_ADDR-1:0] regi_a_rs1;
  logic [LEN_REG_ADDR-1:0] regi_a_rs2;
  logic [LEN_WORD-1:0]     regi_d_rs1;
  logic [LEN_WORD-1:0]     regi_d_rs2;
  logic                    iss_valid;
  logic [LEN_REG_ADDR-1:0] iss_a_rd;
  logic                    iss_stall;
  logic                    wb_en;
  logic [LEN_REG_ADDR-1:0] wb_a_rd;
  logic [LEN_WORD-1:0]     wb_d_rd;
  logic [LEN_REG_ADDR:0]   busy_cnt;
  logic                    idle;

  modport master (
    output regi_a_rs1, regi_a_rs2, iss_valid, iss_a_rd, wb_en, wb_a_rd, wb_d_rd,
    input  regi_d_rs1, regi_d_rs2, iss_stall, busy_cnt, idle
  );

  modport slave (
    input  regi_a_rs1, regi_a_rs2, iss_valid, iss_a_rd, wb_en, wb_a_rd, wb_d_rd,
    output regi_d_rs1, regi_d_rs2, iss_stall, busy_cnt, idle
  );
endinterface

// File: rtl/reg_file_sb.sv
// Unified int/float register file (2R/1W) with per-register busy scoreboard
// producing the decode->dispatch issue stall and a running busy count.
module reg_file_sb #(
  parameter int unsigned LEN_WORD     = 32,
  parameter int unsigned LEN_REG_ADDR = 6
) (
  input logic          clk,
  input logic          rstn,
  reg_file_sb_if.slave rf
);
  localparam int unsigned NREG = 1 << LEN_REG_ADDR;

  typedef logic [LEN_REG_ADDR-1:0] addr_t;
  typedef logic [LEN_WORD-1:0]     word_t;
  typedef logic [LEN_REG_ADDR:0]   cnt_t;

  localparam addr_t ZERO_ADDR = '0;
  localparam cnt_t  CNT_ONE   = cnt_t'(1);

  word_t           mem [NREG];
  logic [NREG-1:0] busy;
  cnt_t            cnt;

  logic  wr;
  logic  accept;
  logic  stall;
  logic  inc;
  logic  dec;
  logic  eb_rs1;
  logic  eb_rs2;
  logic  eb_rd;
  word_t d_rs1;
  word_t d_rs2;

  // Read ports with same-cycle write-back bypass; x0 is hard-wired to zero.
  always_comb begin
    d_rs1 = '0;
    d_rs2 = '0;
    if (rf.regi_a_rs1 != ZERO_ADDR) begin
      if (rf.wb_en && (rf.wb_a_rd == rf.regi_a_rs1)) d_rs1 = rf.wb_d_rd;
      else                                           d_rs1 = mem[rf.regi_a_rs1];
    end
    if (rf.regi_a_rs2 != ZERO_ADDR) begin
      if (rf.wb_en && (rf.wb_a_rd == rf.regi_a_rs2)) d_rs2 = rf.wb_d_rd;
      else                                           d_rs2 = mem[rf.regi_a_rs2];
    end
  end

  // busy[0] can never be set, so x0 drops out of the hazard check on its own.
  always_comb begin
    eb_rs1 = busy[rf.regi_a_rs1] & ~(rf.wb_en & (rf.wb_a_rd == rf.regi_a_rs1));
    eb_rs2 = busy[rf.regi_a_rs2] & ~(rf.wb_en & (rf.wb_a_rd == rf.regi_a_rs2));
    eb_rd  = busy[rf.iss_a_rd]   & ~(rf.wb_en & (rf.wb_a_rd == rf.iss_a_rd));
    stall  = rf.iss_valid & (eb_rs1 | eb_rs2 | eb_rd);
    wr     = rf.wb_en & (rf.wb_a_rd != ZERO_ADDR);
    accept = rf.iss_valid & ~stall & (rf.iss_a_rd != ZERO_ADDR);
    // A clear that coincides with a re-issue of the same register is not a net change.
    inc    = accept & ~busy[rf.iss_a_rd];
    dec    = wr & busy[rf.wb_a_rd] & ~(accept & (rf.iss_a_rd == rf.wb_a_rd));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREG; i++) mem[addr_t'(i)] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr) begin
        mem[rf.wb_a_rd]  <= rf.wb_d_rd;
        busy[rf.wb_a_rd] <= 1'b0;
      end
      // Later assignment wins: issue takes priority over write-back clear.
      if (accept) busy[rf.iss_a_rd] <= 1'b1;
      if (inc && !dec)      cnt <= cnt + CNT_ONE;
      else if (dec && !inc) cnt <= cnt - CNT_ONE;
    end
  end

  always_comb begin
    rf.regi_d_rs1 = d_rs1;
    rf.regi_d_rs2 = d_rs2;
    rf.iss_stall  = stall;
    rf.busy_cnt   = cnt;
    rf.idle       = (cnt == '0);
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: per-cycle expected outputs from an array-based model
// are queued by the driver and checked by an independent monitor.
module tb_reg_file_sb;
  logic clk;
  logic rstn;

  reg_file_sb_if #(.LEN_WORD(32), .LEN_REG_ADDR(6)) bus ();

  reg_file_sb #(.LEN_WORD(32), .LEN_REG_ADDR(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rf   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        stall;
    logic [6:0]  cnt;
    logic        idle;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_reg [64];
  bit          m_busy[64];

  function automatic void chk(string tag, string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", tag, nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_read(logic [5:0] a, logic wbe, logic [5:0] wba, logic [31:0] wbd);
    if (a == 0) return '0;
    if (wbe && wba == a) return wbd;
    return m_reg[a];
  endfunction

  function automatic bit m_eb(logic [5:0] a, logic wbe, logic [5:0] wba);
    return (a != 0) && m_busy[a] && !(wbe && wba == a);
  endfunction

  function automatic logic [5:0] rnd_addr();
    logic [5:0] a;
    a = 6'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) a[5] = 1'b1;
    return a;
  endfunction

  // One cycle of stimulus; pulse drops rstn briefly between edges.
  task automatic cyc(input string tag, input logic vld, input logic [5:0] rd,
                     input logic [5:0] rs1, input logic [5:0] rs2, input logic wbe,
                     input logic [5:0] wba, input logic [31:0] wbd, input bit pulse = 1'b0);
    exp_t e;
    int   c;
    bit   stl;
    @(negedge clk);
    bus.iss_valid  = vld;
    bus.iss_a_rd   = rd;
    bus.regi_a_rs1 = rs1;
    bus.regi_a_rs2 = rs2;
    bus.wb_en      = wbe;
    bus.wb_a_rd    = wba;
    bus.wb_d_rd    = wbd;
    if (pulse) begin
      #1;
      rstn = 1'b0;
      model_reset();
    end
    c = 0;
    for (int i = 0; i < 64; i++) if (m_busy[i]) c++;
    stl     = vld && (m_eb(rs1, wbe, wba) || m_eb(rs2, wbe, wba) || m_eb(rd, wbe, wba));
    e.tag   = tag;
    e.d1    = m_read(rs1, wbe, wba, wbd);
    e.d2    = m_read(rs2, wbe, wba, wbd);
    e.stall = stl;
    e.cnt   = 7'(c);
    e.idle  = (c == 0);
    sb.push_back(e);
    if (pulse) begin
      #2;
      rstn = 1'b1;
    end
    if (rstn) begin
      if (wbe && wba != 0) begin
        m_reg[wba]  = wbd;
        m_busy[wba] = 1'b0;
      end
      if (vld && !stl && rd != 0) m_busy[rd] = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.tag, "rd1",   bus.regi_d_rs1, e.d1);
        chk(e.tag, "rd2",   bus.regi_d_rs2, e.d2);
        chk(e.tag, "stall", 32'(bus.iss_stall), 32'(e.stall));
        chk(e.tag, "cnt",   32'(bus.busy_cnt),  32'(e.cnt));
        chk(e.tag, "idle",  32'(bus.idle),      32'(e.idle));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [5:0] a;
    rstn           = 1'b0;
    bus.iss_valid  = 1'b0;
    bus.iss_a_rd   = '0;
    bus.regi_a_rs1 = '0;
    bus.regi_a_rs2 = '0;
    bus.wb_en      = 1'b0;
    bus.wb_a_rd    = '0;
    bus.wb_d_rd    = '0;
    model_reset();

    for (int i = 0; i < 32; i++) cyc("rst_read", 0, 0, 6'(i), 6'(i + 32), 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;

    cyc("byp",      0, 0, 5, 0, 1, 5, 32'hDEADBEEF);
    cyc("stored",   0, 0, 5, 0, 1, 0, 32'h00001234);
    cyc("x0_drop",  0, 0, 0, 5, 0, 0, 0);

    cyc("raw_iss",  1, 33, 0, 0, 0, 0, 0);
    cyc("raw_stl",  1, 10, 0, 33, 0, 0, 0);
    cyc("raw_wb",   1, 10, 0, 33, 1, 33, 32'h3F800000);

    cyc("waw_iss",  1, 7, 0, 0, 0, 0, 0);
    cyc("waw_race", 1, 7, 0, 0, 1, 7, 32'h11);
    cyc("waw_chk",  1, 0, 7, 7, 0, 0, 0);
    cyc("clean7",   0, 0, 7, 10, 1, 7, 32'h77);
    cyc("clean10",  0, 0, 7, 10, 1, 10, 32'hA0);

    for (int k = 1; k < 64; k++) cyc("sat_iss", 1, 6'(k), 0, 0, 0, 0, 0);
    cyc("sat_rd0", 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 64; k++) cyc("sat_wb", 0, 0, 6'(k), 6'(64 - k), 1, 6'(k), $urandom);
    cyc("sat_idle", 0, 0, 63, 32, 0, 0, 0);

    cyc("af_iss",   1, 3, 0, 0, 0, 0, 0);
    cyc("af_iss",   1, 4, 0, 0, 0, 0, 0);
    cyc("af_iss",   1, 35, 0, 0, 0, 0, 0);
    cyc("af_pre",   1, 0, 3, 0, 0, 0, 0);
    cyc("af_rst",   1, 0, 3, 4, 0, 0, 0, 1'b1);
    cyc("af_stale", 0, 0, 35, 0, 1, 35, 32'hCAFEF00D);
    cyc("af_chk",   0, 0, 35, 3, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      a = rnd_addr();
      cyc("rnd", ($urandom_range(0, 9) < 7), rnd_addr(), rnd_addr(), rnd_addr(),
          ($urandom_range(0, 1) == 1), a, $urandom);
    end
    cyc("drain", 0, 0, 0, 0, 0, 0, 0);

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Two-read/one-write register file with scoreboard. It answers the decoder's `regi_a_rs1`/`regi_a_rs2` read requests with `regi_d_rs1`/`regi_d_rs2` data. The register space is unified: 64 entries, where address bit 5 selects the float bank and bits 4:0 select the index. A per-register busy bit tracks results still in flight from multi-cycle units (FPU, memory loads, I/O). From these busy bits the block produces the issue-stall signal that sits between decode and dispatch.

## Interface
Parameters:
- `LEN_WORD`, 32, data width.
- `LEN_REG_ADDR`, 6, register address width; bit 5 = float bank.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `regi_a_rs1`  in  6  read address, port 1.
- `regi_a_rs2`  in  6  read address, port 2.
- `regi_d_rs1`  out  32  read data, port 1 (combinational).
- `regi_d_rs2`  out  32  read data, port 2 (combinational).
- `iss_valid`  in  1  decoder has an instruction to dispatch this cycle.
- `iss_a_rd`  in  6  destination of the issuing instruction; 6'b0 = no destination.
- `iss_stall`  out  1  hazard; the issue is refused this cycle.
- `wb_en`  in  1  write-back strobe.
- `wb_a_rd`  in  6  write-back address.
- `wb_d_rd`  in  32  write-back data.
- `busy_cnt`  out  7  number of set busy bits, 0..63.
- `idle`  out  1  high when `busy_cnt == 0`.

## Operation
- Storage: 64 x 32-bit entries. Address 0 (integer x0) always reads 0; writes to it are dropped and it is never marked busy. Address 32 (f0) is an ordinary register.
- Read port p: if `wb_en` and `wb_a_rd == regi_a_rs{p}` and the address is non-zero, return `wb_d_rd` (same-cycle bypass). Otherwise return the stored value (0 for address 0).
- Write: on the clock edge with `wb_en` and `wb_a_rd != 0`, the entry takes `wb_d_rd` and its busy bit clears.
- Effective busy: `eb[x] = busy[x] & ~(wb_en & wb_a_rd == x)`. The write-back in the current cycle resolves the hazard in the same cycle.
- Stall: `iss_stall = iss_valid & (eb[regi_a_rs1] | eb[regi_a_rs2] | eb[iss_a_rd])`, covering RAW on either source and WAW on the destination. Address 0 never contributes.
- Issue accept: `iss_valid & ~iss_stall & iss_a_rd != 0` sets `busy[iss_a_rd]` at the edge.
- Simultaneous write-back and accepted issue to the same address: the entry takes the write-back data, and the busy bit ends **set**, because issue has priority over clear.
- Write-back to a register that is not busy: data is still written; the busy bit stays 0; no error.
- `busy_cnt` is a registered counter, not a popcount. Per edge: +1 on a set of a clear bit, −1 on a clear of a set bit, unchanged when both happen on the same register or when neither happens. Invariant: `busy_cnt` equals the popcount of `busy` at all times.

## Timing
- Reads are zero-latency combinational. Bypass makes a write visible in the same cycle it is presented.
- A write is visible from storage one cycle after the edge that performs it.
- `iss_stall` is combinational from the same-cycle inputs. There is no registered path from `iss_valid` to `iss_stall`.
- Busy set/clear latency: 1 edge.
- Reset (`rstn` low, asynchronous):
  - all 64 entries = 0, all busy = 0;
  - `busy_cnt` = 0, `idle` = 1;
  - `iss_stall` = 0 (while there is no issue);
  - `regi_d_rs1`/`regi_d_rs2` = 0 unless a bypass is active.
- Reset asserted mid-operation discards all in-flight busy state immediately. Write-backs arriving after deassertion are treated as writes to non-busy registers.

## Test plan
- Reset check: after reset, read every address on both ports -> all 0; `busy_cnt` = 0, `idle` = 1.
- Write-back and bypass: `wb_en`, addr 5, data 0xDEADBEEF, with `regi_a_rs1` = 5 in the same cycle -> `regi_d_rs1` = 0xDEADBEEF before the edge and stays so after it. Write-back to addr 0 with 0x1234 -> reads 0.
- RAW stall: issue rd = 33 (f1) -> `busy_cnt` = 1. Next cycle, issue with rs2 = 33 -> `iss_stall` = 1. Present a write-back to 33 with 0x3F800000 in that cycle -> `iss_stall` = 0 and `regi_d_rs2` = 0x3F800000.
- WAW and same-address race: issue rd = 7 is accepted. Then present, in the same cycle, write-back 7 = 0x11 and issue rd = 7 -> no stall; afterwards `busy[7]` = 1, entry = 0x11, `busy_cnt` unchanged at 1.
- Counter saturation: issue rd = 1..63 on consecutive cycles -> `busy_cnt` = 63; an issue with rd = 0 is accepted and the count stays 63; write back all 63 -> `busy_cnt` = 0, `idle` = 1.
- Async reset mid-flight: with 3 busy registers, pulse `rstn` low between edges -> `busy_cnt` = 0 and `iss_stall` = 0 immediately; a stale write-back to one of the registers afterwards writes its data and `busy_cnt` stays 0.
